// File: rtl/logic_gate_pkg.sv
// Shared op encodings and the per-bit gate evaluation used by logic_gate_pipe.
package logic_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NAND   = 3'd0;
    localparam op_t OP_NOR    = 3'd1;
    localparam op_t OP_AND    = 3'd2;
    localparam op_t OP_OR     = 3'd3;
    localparam op_t OP_XOR    = 3'd4;
    localparam op_t OP_XNOR   = 3'd5;
    localparam op_t OP_NOT_A  = 3'd6;
    localparam op_t OP_PASS_A = 3'd7;

    // Bit-level so the same function serves any operand width.
    function automatic logic gate_bit(input op_t op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_XNOR:   r = ~(a ^ b);
            OP_NOT_A:  r = ~a;
            default:   r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_stage.sv
// One pipeline slot: valid bit, result word and reduction flags, with its own advance logic.
module logic_gate_stage
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_any,
    input  logic             prev_all,
    input  logic             next_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             flag_any,
    output logic             flag_all,
    output logic             advance
);

    assign advance = ~valid | next_ready;

    // NOTE: state registers use non-blocking assignment so every slot samples its
    // neighbour's pre-edge value; blocking here would let items skip slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            // NOTE: the payload is reset as well, because the last slot drives
            // out_data/out_any/out_all directly and those must read 0 after reset.
            data     <= '0;
            flag_any <= 1'b0;
            flag_all <= 1'b0;
        end else if (advance) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data     <= prev_data;
                flag_any <= prev_any;
                flag_all <= prev_all;
            end
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined WIDTH-bit logic unit with valid/ready streaming, reduction flags and a
// saturating output-transfer counter.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_any,
    output logic             out_all,
    input  logic             clr_count,
    output logic [CNT_W-1:0] txn_count
);

    logic [WIDTH-1:0] entry_data;
    logic             entry_any;
    logic             entry_all;

    // NOTE: every always_comb output gets a default before the loop so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        entry_data = '0;
        for (int i = 0; i < WIDTH; i++) begin
            entry_data[i] = gate_bit(op_t'(in_op), in_a[i], in_b[i]);
        end
    end

    assign entry_any = |entry_data;
    assign entry_all = &entry_data;

    // Separate per-slot signals keep the backward ready chain free of self-dependent vectors.
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        logic             prev_any;
        logic             prev_all;
        logic             next_ready;
        logic             valid;
        logic [WIDTH-1:0] data;
        logic             flag_any;
        logic             flag_all;
        logic             advance;

        if (k == 0) begin : g_head
            assign prev_valid = in_valid;
            assign prev_data  = entry_data;
            assign prev_any   = entry_any;
            assign prev_all   = entry_all;
        end else begin : g_link
            assign prev_valid = g_slot[k-1].valid;
            assign prev_data  = g_slot[k-1].data;
            assign prev_any   = g_slot[k-1].flag_any;
            assign prev_all   = g_slot[k-1].flag_all;
        end

        if (k == STAGES - 1) begin : g_tail
            assign next_ready = out_ready;
        end else begin : g_mid
            assign next_ready = g_slot[k+1].advance;
        end

        logic_gate_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .prev_any   (prev_any),
            .prev_all   (prev_all),
            .next_ready (next_ready),
            .valid      (valid),
            .data       (data),
            .flag_any   (flag_any),
            .flag_all   (flag_all),
            .advance    (advance)
        );
    end

    // in_ready depends combinationally on out_ready through the advance chain.
    assign in_ready  = g_slot[0].advance;
    assign out_valid = g_slot[STAGES-1].valid;
    assign out_data  = g_slot[STAGES-1].data;
    assign out_any   = g_slot[STAGES-1].flag_any;
    assign out_all   = g_slot[STAGES-1].flag_all;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (clr_count) begin
            txn_count <= '0;
        end else if (out_valid && out_ready && (txn_count != '1)) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: queue-based reference model plus directed literal checks.
module tb_logic_gate_pipe;
    import logic_gate_pkg::*;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_any;
    logic             out_all;
    logic             clr_count;
    logic [CNT_W-1:0] txn_count;

    logic_gate_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_any   (out_any),
        .out_all   (out_all),
        .clr_count (clr_count),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } item_t;

    item_t            exp_q[$];
    logic [CNT_W-1:0] mcnt;

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return ~(a | b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: items leave in order, the head becomes visible STAGES cycles after
    // its input transfer, and the unit is full only when STAGES items are held.
    initial begin
        logic             exp_valid;
        logic [WIDTH-1:0] e;
        mcnt = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_txn_count", txn_count, 0);
                exp_q.delete();
                mcnt = '0;
            end else begin
                exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + STAGES);
                check("out_valid", out_valid, exp_valid);
                check("in_ready", in_ready, (exp_q.size() < STAGES) || (exp_valid && out_ready));
                check("txn_count", txn_count, mcnt);
                if (exp_valid) begin
                    e = exp_q[0].data;
                    check("out_data", out_data, e);
                    check("out_any", out_any, |e);
                    check("out_all", out_all, &e);
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (clr_count) mcnt = '0;
                else if (exp_valid && out_ready && (mcnt != '1)) mcnt = mcnt + 1'b1;
                if (in_valid && in_ready)
                    exp_q.push_back(item_t'{data: model(in_op, in_a, in_b), cyc: cyc});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic push(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("push_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [WIDTH-1:0] d,
                              input logic any_v, input logic all_v);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, d);
        check({name, "_any"}, out_any, any_v);
        check({name, "_all"}, out_all, all_v);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 3'd0;
        out_ready = 1'b1;
        clr_count = 1'b0;

        check("model_nand", model(OP_NAND, 8'hF0, 8'hCC), 8'h3F);
        check("model_xnor", model(OP_XNOR, 8'h0F, 8'h0C), 8'hFC);

        #2 rst_n = 1'b0;
        #1;
        check("reset_data", out_data, 0);
        check("reset_any", out_any, 0);
        check("reset_all", out_all, 0);
        check("reset_count", txn_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // NAND F0/CC appears two cycles after entry
        push(OP_NAND, 8'hF0, 8'hCC);
        step();
        expect_out("t1_nand", 8'h3F, 1'b1, 1'b0);

        push(OP_NAND, 8'hFF, 8'hFF);
        step();
        expect_out("t2_nand_ff", 8'h00, 1'b0, 1'b0);
        push(OP_NOR, 8'h00, 8'h00);
        step();
        expect_out("t2_nor_00", 8'hFF, 1'b1, 1'b1);
        push(OP_XOR, 8'hA5, 8'hFF);
        step();
        expect_out("t2_xor", 8'h5A, 1'b1, 1'b0);
        push(OP_PASS_A, 8'h81, 8'h33);
        step();
        expect_out("t2_pass", 8'h81, 1'b1, 1'b0);
        step();

        // Backpressure: two items fill the pipe, the third waits
        out_ready = 1'b0;
        push(OP_AND, 8'h3C, 8'h0F);
        push(OP_OR, 8'h30, 8'h03);
        in_valid = 1'b1;
        in_op    = OP_XNOR;
        in_a     = 8'hF0;
        in_b     = 8'h0F;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t3_full_in_ready", in_ready, 0);
            check("t3_hold_data", out_data, 8'h0C);
        end
        step();
        out_ready = 1'b1;
        #1;
        check("t3_pop_push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        expect_out("t3_second", 8'h33, 1'b1, 1'b0);
        step();
        expect_out("t3_third", 8'h00, 1'b0, 1'b0);
        step();
        check("t3_drained", out_valid, 0);
        check("t3_count", txn_count, 8);

        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check("clr_idle", txn_count, 0);

        // Ten back-to-back items at full throughput
        for (int i = 0; i < 10; i++) push(3'(i % 8), 8'(i * 17), 8'h5A);
        repeat (3) step();
        check("t6_count", txn_count, 10);

        // Saturation after 17 transfers, then clear wins over a concurrent transfer
        for (int i = 0; i < 7; i++) push(OP_NOT_A, 8'(i * 3), 8'h00);
        repeat (3) step();
        check("t4_saturated", txn_count, 4'hF);
        push(OP_NAND, 8'h00, 8'h00);
        step();
        check("t4_xfer_pending", out_valid, 1);
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        check("t4_clr_priority", txn_count, 0);

        push(OP_XOR, 8'h0F, 8'hF0);
        repeat (2) step();
        check("t5_pre_count", txn_count, 1);

        // Reset with two items in flight
        out_ready = 1'b0;
        push(OP_OR, 8'h11, 8'h22);
        push(OP_AND, 8'hFF, 8'h0F);
        check("t5_loaded", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_count", txn_count, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            step();
            check("t5_no_ghost", out_valid, 0);
        end

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
